// File: rtl/mem_stage_lsu.sv
// EX/MEM pipeline register with a data-memory load/store handshake.
// Handles byte/halfword lanes, load sign/zero extension, misalignment
// suppression and a bounded wait for dmem_ack.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_mem,
  input  logic        valid_ex,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic [2:0]  funct3_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemtoReg_ex,
  output logic        valid_mem,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic        MemtoReg_mem,
  output logic [31:0] MemReadData_mem,
  output logic        misalign_mem,
  output logic        bus_err_mem,
  output logic        stall_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int unsigned CW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;

  logic [31:0]     wdata_r;
  logic [31:0]     rdata_r;
  logic [2:0]      funct3_r;
  logic            memread_r;
  logic            memwrite_r;
  logic            regwrite_r;

  logic            take_ex;
  logic            memop_ex;
  logic            misalign_ex;
  logic            start_ex;
  logic            timeout_hit;

  // funct3[1:0]: 00 byte, 01 half, anything else word; funct3[2] selects zero-extend
  always_comb begin
    take_ex     = valid_ex && !flush_mem;
    memop_ex    = take_ex && (MemRead_ex || MemWrite_ex);
    misalign_ex = 1'b0;
    if (funct3_ex[1:0] == 2'b01)
      misalign_ex = ALUResult_ex[0];
    else if (funct3_ex[1:0] != 2'b00)
      misalign_ex = (ALUResult_ex[1:0] != 2'b00);
    misalign_ex = misalign_ex && memop_ex;
    start_ex    = memop_ex && !misalign_ex;
  end

  assign stall_mem   = (state == BUSY);
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // FSM state and timeout counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: IDLE and DONE both behave as capture edges
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      BUSY: begin
        if (dmem_ack || timeout_hit)
          state_next = DONE;
        else
          cnt_next = cnt + CW'(1);
      end
      default: state_next = start_ex ? BUSY : IDLE;
    endcase
  end

  // Pipeline register: captures EX on non-stalled edges, latches read data in BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mem     <= 1'b0;
      ALUResult_mem <= '0;
      wdata_r       <= '0;
      rdAddr_mem    <= '0;
      regwrite_r    <= 1'b0;
      MemtoReg_mem  <= 1'b0;
      memread_r     <= 1'b0;
      memwrite_r    <= 1'b0;
      funct3_r      <= '0;
      misalign_mem  <= 1'b0;
      bus_err_mem   <= 1'b0;
      rdata_r       <= '0;
    end else if (!stall_mem) begin
      valid_mem     <= take_ex;
      ALUResult_mem <= ALUResult_ex;
      wdata_r       <= MemWriteData_ex;
      rdAddr_mem    <= rdAddr_ex;
      regwrite_r    <= take_ex && RegWrite_ex;
      MemtoReg_mem  <= MemtoReg_ex;
      memread_r     <= take_ex && MemRead_ex;
      memwrite_r    <= take_ex && MemWrite_ex;
      funct3_r      <= funct3_ex;
      misalign_mem  <= misalign_ex;
      bus_err_mem   <= 1'b0;
      rdata_r       <= '0;
    end else if (dmem_ack) begin
      rdata_r <= dmem_rdata;
    end else if (timeout_hit) begin
      bus_err_mem <= 1'b1;
      rdata_r     <= '0;
    end
  end

  assign RegWrite_mem = regwrite_r && !misalign_mem && !bus_err_mem;

  // Bus drive: lane replication and byte enables from the held address
  always_comb begin
    dmem_req   = stall_mem;
    dmem_we    = memwrite_r;
    dmem_addr  = {ALUResult_mem[31:2], 2'b00};
    dmem_wdata = wdata_r;
    dmem_be    = 4'b1111;
    if (memwrite_r) begin
      case (funct3_r[1:0])
        2'b00: begin
          dmem_wdata = {4{wdata_r[7:0]}};
          dmem_be    = 4'b0001 << ALUResult_mem[1:0];
        end
        2'b01: begin
          dmem_wdata = {2{wdata_r[15:0]}};
          dmem_be    = ALUResult_mem[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  // Load extraction from the latched word; zero outside DONE
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h00;
    case (ALUResult_mem[1:0])
      2'b00:   b = rdata_r[7:0];
      2'b01:   b = rdata_r[15:8];
      2'b10:   b = rdata_r[23:16];
      default: b = rdata_r[31:24];
    endcase
    h = ALUResult_mem[1] ? rdata_r[31:16] : rdata_r[15:0];
    MemReadData_mem = '0;
    if (state == DONE && memread_r) begin
      case (funct3_r[1:0])
        2'b00:   MemReadData_mem = funct3_r[2] ? {24'h0, b} : {{24{b[7]}}, b};
        2'b01:   MemReadData_mem = funct3_r[2] ? {16'h0, h} : {{16{h[15]}}, h};
        default: MemReadData_mem = rdata_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_mem = 1'b0;
  logic        valid_ex = 1'b0;
  logic [31:0] ALUResult_ex = '0;
  logic [31:0] MemWriteData_ex = '0;
  logic        MemRead_ex = 1'b0;
  logic        MemWrite_ex = 1'b0;
  logic [2:0]  funct3_ex = '0;
  logic [4:0]  rdAddr_ex = '0;
  logic        RegWrite_ex = 1'b0;
  logic        MemtoReg_ex = 1'b0;
  logic        valid_mem;
  logic [31:0] ALUResult_mem;
  logic [4:0]  rdAddr_mem;
  logic        RegWrite_mem;
  logic        MemtoReg_mem;
  logic [31:0] MemReadData_mem;
  logic        misalign_mem;
  logic        bus_err_mem;
  logic        stall_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush_mem(flush_mem), .valid_ex(valid_ex),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex), .funct3_ex(funct3_ex),
    .rdAddr_ex(rdAddr_ex), .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex),
    .valid_mem(valid_mem), .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem),
    .RegWrite_mem(RegWrite_mem), .MemtoReg_mem(MemtoReg_mem),
    .MemReadData_mem(MemReadData_mem), .misalign_mem(misalign_mem),
    .bus_err_mem(bus_err_mem), .stall_mem(stall_mem), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    valid_ex = 1'b0; flush_mem = 1'b0; MemRead_ex = 1'b0; MemWrite_ex = 1'b0;
    RegWrite_ex = 1'b0; MemtoReg_ex = 1'b0; ALUResult_ex = '0;
    MemWriteData_ex = '0; funct3_ex = '0; rdAddr_ex = '0;
  endtask

  task automatic set_ex(input logic [31:0] alu, input logic [31:0] wd, input logic rd_en,
                        input logic wr_en, input logic [2:0] f3, input logic [4:0] rd,
                        input logic rw, input logic m2r);
    valid_ex = 1'b1; flush_mem = 1'b0; ALUResult_ex = alu; MemWriteData_ex = wd;
    MemRead_ex = rd_en; MemWrite_ex = wr_en; funct3_ex = f3; rdAddr_ex = rd;
    RegWrite_ex = rw; MemtoReg_ex = m2r;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({valid_mem, RegWrite_mem, stall_mem, dmem_req, misalign_mem, bus_err_mem} !== 6'b0 ||
        ALUResult_mem !== 32'h0 || MemReadData_mem !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b rw=%b stall=%b req=%b alu=%h rdata=%h, all required 0",
               valid_mem, RegWrite_mem, stall_mem, dmem_req, ALUResult_mem, MemReadData_mem);
    end
    #10 rst_n = 1'b1;
    tick();
    // reset asserted in the middle of an outstanding access
    set_ex(32'h600, 32'h0, 1'b1, 1'b0, 3'b010, 5'd9, 1'b1, 1'b1);
    dmem_ack = 1'b0;
    tick();
    bubble();
    checks++;
    if (dmem_req !== 1'b1 || stall_mem !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy: req=%b stall=%b, required 1 1", dmem_req, stall_mem);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_mem !== 1'b0 || valid_mem !== 1'b0 ||
        ALUResult_mem !== 32'h0 || RegWrite_mem !== 1'b0 || rdAddr_mem !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_busy: req=%b stall=%b valid=%b alu=%h rw=%b rd=%0d, required all 0",
               dmem_req, stall_mem, valid_mem, ALUResult_mem, RegWrite_mem, rdAddr_mem);
    end
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_after: req=%b stall=%b, required 0 0", dmem_req, stall_mem);
    end
  endtask

  task automatic test_add();
    set_ex(32'h1234, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1, 1'b0);
    tick();
    checks++;
    if (ALUResult_mem !== 32'h1234 || rdAddr_mem !== 5'd5 || RegWrite_mem !== 1'b1 ||
        valid_mem !== 1'b1 || stall_mem !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL add_nonmem: alu=%h rd=%0d rw=%b valid=%b stall=%b req=%b, required 1234 5 1 1 0 0",
               ALUResult_mem, rdAddr_mem, RegWrite_mem, valid_mem, stall_mem, dmem_req);
    end
    bubble();
    tick();
  endtask

  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] expected, input string name);
    int stalls;
    dmem_rdata = 32'h80FF_0000;
    dmem_ack   = 1'b1;
    set_ex(32'h103, 32'h0, 1'b1, 1'b0, f3, 5'd7, 1'b1, 1'b1);
    tick();
    bubble();
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== 4'b1111 || dmem_addr !== 32'h100) begin
      errors++;
      $display("FAIL %s_bus: req=%b we=%b be=%b addr=%h, required 1 0 1111 00000100",
               name, dmem_req, dmem_we, dmem_be, dmem_addr);
    end
    stalls = 0;
    for (int i = 0; i < 40 && stall_mem === 1'b1; i++) begin
      stalls++;
      tick();
    end
    checks++;
    if (stalls !== 1) begin
      errors++;
      $display("FAIL %s_stall_cycles: got %0d, required 1", name, stalls);
    end
    checks++;
    if (MemReadData_mem !== expected || RegWrite_mem !== 1'b1 || rdAddr_mem !== 5'd7) begin
      errors++;
      $display("FAIL %s_data: data=%h rw=%b rd=%0d, required %h 1 7",
               name, MemReadData_mem, RegWrite_mem, rdAddr_mem, expected);
    end
    dmem_ack = 1'b0;
    tick();
  endtask

  task automatic test_store_half();
    int stalls;
    dmem_ack = 1'b0;
    set_ex(32'h202, 32'hABCD_1234, 1'b0, 1'b1, 3'b001, 5'd0, 1'b0, 1'b0);
    tick();
    bubble();
    checks++;
    if (dmem_addr !== 32'h200 || dmem_wdata !== 32'h1234_1234 || dmem_be !== 4'b1100 ||
        dmem_we !== 1'b1 || dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL sh_bus: addr=%h wdata=%h be=%b we=%b req=%b, required 00000200 12341234 1100 1 1",
               dmem_addr, dmem_wdata, dmem_be, dmem_we, dmem_req);
    end
    stalls = 1;
    tick();
    if (stall_mem === 1'b1) stalls++;
    dmem_ack = 1'b1;
    #1 dmem_ack = 1'b0;
    #1;
    checks++;
    if (stall_mem !== 1'b1) begin
      errors++;
      $display("FAIL sh_pulse_outside_edge: stall=%b, required 1", stall_mem);
    end
    tick();
    if (stall_mem === 1'b1) stalls++;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    checks++;
    if (stalls !== 3 || stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL sh_stall_cycles: got %0d (stall now %b), required 3 (0)", stalls, stall_mem);
    end
    tick();
  endtask

  task automatic test_misalign();
    set_ex(32'h101, 32'h0, 1'b1, 1'b0, 3'b010, 5'd4, 1'b1, 1'b1);
    tick();
    bubble();
    checks++;
    if (misalign_mem !== 1'b1 || dmem_req !== 1'b0 || RegWrite_mem !== 1'b0 ||
        stall_mem !== 1'b0 || valid_mem !== 1'b1) begin
      errors++;
      $display("FAIL lw_misalign: mis=%b req=%b rw=%b stall=%b valid=%b, required 1 0 0 0 1",
               misalign_mem, dmem_req, RegWrite_mem, stall_mem, valid_mem);
    end
    tick();
  endtask

  task automatic test_timeout();
    int busy;
    dmem_ack = 1'b0;
    set_ex(32'h300, 32'h0, 1'b1, 1'b0, 3'b010, 5'd6, 1'b1, 1'b1);
    tick();
    bubble();
    checks++;
    if (ALUResult_mem !== 32'h300 || RegWrite_mem !== 1'b1 || rdAddr_mem !== 5'd6) begin
      errors++;
      $display("FAIL timeout_fwd_hold: alu=%h rw=%b rd=%0d, required 00000300 1 6",
               ALUResult_mem, RegWrite_mem, rdAddr_mem);
    end
    busy = 0;
    for (int i = 0; i < 40 && stall_mem === 1'b1; i++) begin
      busy++;
      tick();
    end
    checks++;
    if (busy !== 16) begin
      errors++;
      $display("FAIL timeout_busy_cycles: got %0d, required 16", busy);
    end
    checks++;
    if (bus_err_mem !== 1'b1 || RegWrite_mem !== 1'b0 || stall_mem !== 1'b0 ||
        MemReadData_mem !== 32'h0) begin
      errors++;
      $display("FAIL timeout_result: err=%b rw=%b stall=%b data=%h, required 1 0 0 0",
               bus_err_mem, RegWrite_mem, stall_mem, MemReadData_mem);
    end
    tick();
    checks++;
    if (bus_err_mem !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_clear: err=%b, required 0", bus_err_mem);
    end
  endtask

  task automatic test_flush();
    set_ex(32'h400, 32'h0, 1'b1, 1'b0, 3'b010, 5'd8, 1'b1, 1'b1);
    flush_mem = 1'b1;
    tick();
    bubble();
    checks++;
    if (valid_mem !== 1'b0 || dmem_req !== 1'b0 || stall_mem !== 1'b0 || RegWrite_mem !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: valid=%b req=%b stall=%b rw=%b, required 0 0 0 0",
               valid_mem, dmem_req, stall_mem, RegWrite_mem);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    dmem_rdata = 32'hDEAD_BEEF;
    dmem_ack   = 1'b1;
    set_ex(32'h500, 32'h0, 1'b1, 1'b0, 3'b010, 5'd2, 1'b1, 1'b1);
    tick();
    set_ex(32'h77, 32'h0, 1'b0, 1'b0, 3'b000, 5'd3, 1'b1, 1'b0);
    checks++;
    if (stall_mem !== 1'b1 || ALUResult_mem !== 32'h500 || rdAddr_mem !== 5'd2) begin
      errors++;
      $display("FAIL b2b_busy: stall=%b alu=%h rd=%0d, required 1 00000500 2",
               stall_mem, ALUResult_mem, rdAddr_mem);
    end
    tick();
    checks++;
    if (MemReadData_mem !== 32'hDEAD_BEEF || ALUResult_mem !== 32'h500 || stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: data=%h alu=%h stall=%b, required deadbeef 00000500 0",
               MemReadData_mem, ALUResult_mem, stall_mem);
    end
    dmem_ack = 1'b0;
    tick();
    bubble();
    checks++;
    if (ALUResult_mem !== 32'h77 || rdAddr_mem !== 5'd3 || RegWrite_mem !== 1'b1 ||
        stall_mem !== 1'b0 || MemReadData_mem !== 32'h0) begin
      errors++;
      $display("FAIL b2b_next: alu=%h rd=%0d rw=%b stall=%b data=%h, required 00000077 3 1 0 0",
               ALUResult_mem, rdAddr_mem, RegWrite_mem, stall_mem, MemReadData_mem);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_byte(3'b000, 32'hFFFF_FF80, "lb");
    test_load_byte(3'b100, 32'h0000_0080, "lbu");
    test_store_half();
    test_misalign();
    test_timeout();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
